pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register that generalises the fixed MEM/WB latch.
- Carries LANES data words, a control bundle and a write-back register address between two pipeline stages.
- Uses a valid/ready handshake with a one-entry skid buffer, so stall back-pressure is taken off the upstream combinational path.
- Supports flush (bubble insertion), gates control bits on invalid slots, and counts stall cycles for performance monitoring.

Parameters:
- DATA_W, 32, width of one data lane
- LANES, 2, number of data lanes (e.g. ALU result and memory read data)
- CTRL_W, 2, width of control bundle (e.g. {RegWrite, MemtoReg})
- ADDR_W, 5, width of write-back register address
- STALL_CNT_W, 16, width of saturating stall counter

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset
- stall_i  in  1  downstream stall; holds the output register
- flush_i  in  1  discards all held entries this edge
- valid_i  in  1  upstream entry valid
- ready_o  out  1  stage can accept an entry this cycle
- data_i  in  DATA_W*LANES  lane k occupies bits [k*DATA_W +: DATA_W]
- ctrl_i  in  CTRL_W  control bundle
- wbaddr_i  in  ADDR_W  write-back register address
- valid_o  out  1  output entry valid
- ready_i  in  1  downstream can accept
- data_o  out  DATA_W*LANES  registered data
- ctrl_o  out  CTRL_W  registered control, forced to 0 when valid_o=0
- wbaddr_o  out  ADDR_W  registered write-back address
- stall_cnt_o  out  STALL_CNT_W  saturating count of stalled output cycles

Behaviour:
- Storage:
  - Main register M: m_valid, m_data, m_ctrl, m_addr.
  - Skid register S: s_valid, s_data, s_ctrl, s_addr.
- Reset (rst_i=0, asynchronous):
  - m_valid=s_valid=0; all data, ctrl and addr fields =0; stall_cnt_o=0.
  - Outputs: valid_o=0, ctrl_o=0, data_o=0, wbaddr_o=0, ready_o=1.
  - Reset asserted mid-transfer drops every entry, with no partial update.
- Derived signals (combinational):
  - ready_o = ~s_valid.
  - take = valid_i & ready_o.
  - drain = m_valid & ready_i & ~stall_i.
  - valid_o = m_valid; data_o = m_data; wbaddr_o = m_addr.
  - ctrl_o = m_valid ? m_ctrl : 0. Bubbles never assert RegWrite.
- Priority at each rising edge: reset > flush > normal.
- Flush (flush_i=1):
  - m_valid<=0, s_valid<=0; any input offered this edge is discarded.
  - Data and addr fields hold their values; ctrl_o reads 0 the next cycle.
  - Counter is unaffected.
- Normal operation, evaluated per edge:
  - M empty or drain=1:
    - If s_valid: M<=S, s_valid<=0. A take in the same edge is impossible because ready_o=0.
    - Else if take: M<=input.
    - Else: m_valid<=0 when drain=1; otherwise M holds.
  - M full and drain=0:
    - If take: S<=input, s_valid<=1.
    - M holds.
  - Simultaneous drain and take with s_valid=0: input goes directly to M. Throughput is 1 entry/cycle, latency 1 cycle.
- ready_o rule: deasserts only the cycle after an entry lands in S. It re-asserts the cycle after S empties into M, or after a flush.
- Ordering: strict FIFO. S is always older than any later input; no entry is lost or duplicated except by flush.
- stall_i overrides ready_i: stall_i=1 with ready_i=1 still holds M.
- Stall counter:
  - Increments when m_valid & ~(ready_i & ~stall_i) & ~flush_i.
  - Saturates at all-ones; no wrap.
  - Cleared only by reset.
- Widths: all fields are copied bit-exact; no arithmetic on data.

Test Plan:
- Reset then pass-through:
  - Stimulus: release rst_i; valid_i=1, data_i={32'hDEAD_BEEF, 32'h0000_0010}, ctrl_i=2'b11, wbaddr_i=5'd7; ready_i=1, stall_i=0.
  - Required: next cycle valid_o=1, data_o matches, ctrl_o=2'b11, wbaddr_o=7. Before the first edge all outputs are 0 and ready_o=1.
- Stall fills skid:
  - Stimulus: entries A (addr 1), B (2), C (3) on consecutive cycles; stall_i=1 from the cycle A is in M.
  - Required: M=A, S=B, ready_o=0, and C is held upstream. On release the output sequence is A, B, C on consecutive cycles with ready_o=1 again. stall_cnt_o equals the number of stalled cycles, e.g. 3.
- Flush with full M and S:
  - Stimulus: assert flush_i one cycle with ctrl=2'b11 held.
  - Required: next cycle valid_o=0, ctrl_o=2'b00, ready_o=1; the input offered on the flush edge is dropped.
- Back-to-back streaming:
  - Stimulus: 8 entries (addr 0..7) with ready_i=1, stall_i=0.
  - Required: valid_o high for 8 consecutive cycles in order, ready_o never deasserts, stall_cnt_o=0.
- Counter saturation:
  - Stimulus: STALL_CNT_W=4, M valid, ready_i=0 for 20 cycles.
  - Required: stall_cnt_o stops at 4'hF.
- Async reset mid-stall:
  - Stimulus: M and S full; pull rst_i low between edges.
  - Required: valid_o=0, ctrl_o=0 and ready_o=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between two pipeline stages: valid/ready plus
// LANES data words, a control bundle and a write-back register address.
//   master: drives valid, data, ctrl, wbaddr; samples ready
//   slave : samples valid, data, ctrl, wbaddr; drives ready
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 2,
  parameter int CTRL_W = 2,
  parameter int ADDR_W = 5
);

  logic                      valid;
  logic                      ready;
  logic [DATA_W*LANES-1:0]   data;
  logic [CTRL_W-1:0]         ctrl;
  logic [ADDR_W-1:0]         wbaddr;

  modport master (
    output valid,
    output data,
    output ctrl,
    output wbaddr,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  ctrl,
    input  wbaddr,
    output ready
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a one-entry skid buffer, flush and a
// saturating stall counter.
//   clk_i, rst_i (async, active-low), stall_i, flush_i : plain inputs
//   up (slave)  : valid_i/ready_o/data_i/ctrl_i/wbaddr_i
//   dn (master) : valid_o/ready_i/data_o/ctrl_o/wbaddr_o
//   stall_cnt_o : saturating count of stalled output cycles
module pipe_stage_reg #(
  parameter int DATA_W      = 32,
  parameter int LANES       = 2,
  parameter int CTRL_W      = 2,
  parameter int ADDR_W      = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  pipe_stage_reg_if.slave        up,
  pipe_stage_reg_if.master       dn,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  typedef struct packed {
    logic [DATA_W*LANES-1:0] data;
    logic [CTRL_W-1:0]       ctrl;
    logic [ADDR_W-1:0]       addr;
  } entry_t;

  localparam logic [STALL_CNT_W-1:0] CNT_MAX =
    {STALL_CNT_W{1'b1}};

  logic                   m_valid_q;
  logic                   m_valid_d;
  entry_t                 m_q;
  entry_t                 m_d;
  logic                   s_valid_q;
  logic                   s_valid_d;
  entry_t                 s_q;
  entry_t                 s_d;
  logic [STALL_CNT_W-1:0] cnt_q;
  logic [STALL_CNT_W-1:0] cnt_d;

  entry_t in_e;
  logic   take;
  logic   drain;
  logic   out_go;

  assign in_e.data = up.data;
  assign in_e.ctrl = up.ctrl;
  assign in_e.addr = up.wbaddr;

  // ready depends only on the skid flop, never on downstream
  assign up.ready = ~s_valid_q;
  assign take     = up.valid & ~s_valid_q;
  // stall overrides ready
  assign out_go   = dn.ready & ~stall_i;
  assign drain    = m_valid_q & out_go;

  always_comb begin
    m_valid_d = m_valid_q;
    m_d       = m_q;
    s_valid_d = s_valid_q;
    s_d       = s_q;

    if (flush_i) begin
      // payload fields are kept; only valid bits drop
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || drain) begin
      if (s_valid_q) begin
        // skid is older than anything upstream
        m_valid_d = 1'b1;
        m_d       = s_q;
        s_valid_d = 1'b0;
      end else if (take) begin
        m_valid_d = 1'b1;
        m_d       = in_e;
      end else if (drain) begin
        m_valid_d = 1'b0;
      end
    end else if (take) begin
      s_valid_d = 1'b1;
      s_d       = in_e;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (m_valid_q && !out_go && !flush_i
        && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_valid_q <= 1'b0;
      m_q       <= '0;
      s_valid_q <= 1'b0;
      s_q       <= '0;
      cnt_q     <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_q       <= m_d;
      s_valid_q <= s_valid_d;
      s_q       <= s_d;
      cnt_q     <= cnt_d;
    end
  end

  assign dn.valid    = m_valid_q;
  assign dn.data     = m_q.data;
  assign dn.wbaddr   = m_q.addr;
  // bubbles must never carry RegWrite
  assign dn.ctrl     = m_valid_q ? m_q.ctrl : '0;
  assign stall_cnt_o = cnt_q;

endmodule
